// File: rtl/spi_flash_stream_reader_if.sv
// Flash pin and read-byte stream bundle for spi_flash_stream_reader.
// master = the reader engine, slave = flash pins plus byte consumer side.
interface spi_flash_stream_reader_if;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output sck, cs_n, mosi, rd_data, rd_valid,
    input  miso, rd_ready
  );

  modport slave (
    input  sck, cs_n, mosi, rd_data, rd_valid,
    output miso, rd_ready
  );
endinterface

// File: rtl/spi_flash_stream_reader.sv
// SPI mode-0 NOR flash read engine: runtime address/length, valid/ready byte output
// with SCK stall on backpressure. Define SPI_FLASH_FAST_READ_EN for 0x0B + 8 dummy clocks.
//
// state  | meaning
// IDLE   | cs_n high, waiting for start
// CMD    | shifting out the 8-bit read opcode
// ADDR   | shifting out ADDR_W address bits
// DUMMY  | 8 dummy clocks (fast-read build only)
// DATA   | shifting in bytes, stalling SCK while the holding register is full
// FINISH | cs_n high, waiting for the last byte to be taken before done
module spi_flash_stream_reader #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [LEN_W-1:0]      byte_cnt,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  spi_flash_stream_reader_if.master bus
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
`endif
  localparam int TX_W  = 8 + ADDR_W;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = 5;
  localparam logic [DIV_W-1:0] DIV_RLD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
    DUMMY,
`endif
    DATA,
    FINISH
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  rem_cnt;
  logic [TX_W-1:0]   tx_sr;
  logic [7:0]        rx_sr;
  logic              pend;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.sck      <= 1'b0;
      bus.cs_n     <= 1'b1;
      bus.mosi     <= 1'b0;
      bus.rd_data  <= 8'h00;
      bus.rd_valid <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      rem_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      pend         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.rd_valid && bus.rd_ready) bus.rd_valid <= 1'b0;
      // A captured byte waits in rx_sr until the holding register frees up.
      if (pend && (!bus.rd_valid || bus.rd_ready)) begin
        bus.rd_data  <= rx_sr;
        bus.rd_valid <= 1'b1;
        pend         <= 1'b0;
      end

      if (state != IDLE && abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        bus.sck      <= 1'b0;
        bus.cs_n     <= 1'b1;
        bus.mosi     <= 1'b0;
        bus.rd_valid <= 1'b0;
        pend         <= 1'b0;
        div_cnt      <= '0;
        bit_cnt      <= '0;
        rem_cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (byte_cnt == '0) begin
                done <= 1'b1;
              end else begin
                busy     <= 1'b1;
                bus.cs_n <= 1'b0;
                tx_sr    <= {RD_CMD, start_addr};
                bus.mosi <= RD_CMD[7];
                rem_cnt  <= byte_cnt;
                bit_cnt  <= BIT_W'(7);
                div_cnt  <= DIV_RLD;
                state    <= CMD;
              end
            end
          end
          FINISH: begin
            if (!bus.rd_valid) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else if (bus.sck) begin
              // Falling edge: present the next opcode/address bit; zeros follow.
              bus.sck  <= 1'b0;
              div_cnt  <= DIV_RLD;
              tx_sr    <= tx_sr << 1;
              bus.mosi <= tx_sr[TX_W-2];
            end else if (state == DATA && rem_cnt == '0) begin
              if (!pend) begin
                bus.cs_n <= 1'b1;
                state    <= FINISH;
              end
            end else if (!pend) begin
              bus.sck <= 1'b1;
              div_cnt <= DIV_RLD;
              rx_sr   <= {rx_sr[6:0], bus.miso};
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
              end else begin
                bit_cnt <= BIT_W'(7);
                case (state)
                  CMD: begin
                    state   <= ADDR;
                    bit_cnt <= BIT_W'(ADDR_W - 1);
                  end
`ifdef SPI_FLASH_FAST_READ_EN
                  ADDR:  state <= DUMMY;
                  DUMMY: state <= DATA;
`else
                  ADDR:  state <= DATA;
`endif
                  DATA: begin
                    pend    <= 1'b1;
                    rem_cnt <= rem_cnt - 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Scoreboard bench for spi_flash_stream_reader with a behavioural mode-0 flash model.
// Adapts header expectations when SPI_FLASH_FAST_READ_EN is defined.
module tb_spi_flash_stream_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         HDR = 40;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         HDR = 32;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] byte_cnt = '0;
  logic        abort = 1'b0;
  logic        busy, done;

  spi_flash_stream_reader_if bus_if ();

  spi_flash_stream_reader #(.CLK_DIV(2), .ADDR_W(24), .LEN_W(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .start_addr (start_addr),
    .byte_cnt   (byte_cnt),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int first_rise_cyc, last_rise_cyc, last_fall_cyc, cs_fall_cyc, cs_rise_cyc;
  int data_mosi_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int valid_rise_at = 0;
  bit busy_seen = 0;
  bit rv_q = 0;
  logic [39:0] mosi_cap = '0;
  logic [7:0]  flash_data [8];
  logic [7:0]  exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [39:0] hdr_exp(input logic [23:0] a);
`ifdef SPI_FLASH_FAST_READ_EN
    return {CMD, a, 8'h00};
`else
    return {8'h00, CMD, a};
`endif
  endfunction

  always @(posedge sys_clk) cyc++;

  // Flash model: counts rises, shifts data out on falling edges after the header.
  always @(negedge bus_if.cs_n) begin
    rise_cnt = 0;
    mosi_cap = '0;
    data_mosi_err = 0;
    cs_fall_cyc = cyc;
  end
  always @(posedge bus_if.cs_n) cs_rise_cyc = cyc;

  always @(posedge bus_if.sck) begin
    if (!bus_if.cs_n) begin
      rise_cnt++;
      last_rise_cyc = cyc;
      if (rise_cnt == 1) first_rise_cyc = cyc;
      if (rise_cnt <= HDR) mosi_cap = {mosi_cap[38:0], bus_if.mosi};
      else if (bus_if.mosi !== 1'b0) data_mosi_err++;
    end
  end

  always @(negedge bus_if.sck) begin
    last_fall_cyc = cyc;
    if (!bus_if.cs_n && rise_cnt >= HDR) begin
      int k;
      k = rise_cnt - HDR;
      bus_if.miso = (k < 64) ? flash_data[k/8][7 - (k % 8)] : 1'b0;
    end
  end

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
    if (bus_if.rd_valid && !rv_q) valid_rise_at = rise_cnt;
    rv_q = bus_if.rd_valid;
    if (bus_if.rd_valid && bus_if.rd_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_byte actual=%0h required=none", bus_if.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rd_data", bus_if.rd_data, e);
      end
    end
  end

  task automatic start_read(input logic [23:0] a, input logic [15:0] n);
    @(posedge sys_clk); #1;
    start = 1'b1; start_addr = a; byte_cnt = n;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(flash_data[i]);
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (done) begin got = 1; break; end
    end
    chk({nm, "_done_seen"}, got, 1);
    if (got) begin
      chk({nm, "_busy_at_done"}, busy, 0);
      @(negedge sys_clk);
      chk({nm, "_done_one_cycle"}, done, 0);
    end
  endtask

  task automatic wait_rise(input int n, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (rise_cnt >= n) begin got = 1; break; end
    end
    if (!got) chk("wait_rise_timeout", rise_cnt, n);
  endtask

  initial begin
    int hs0, d0, r40;
    bit got;
    bus_if.miso = 1'b0;
    bus_if.rd_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sck", bus_if.sck, 0);
    chk("rst_cs_n", bus_if.cs_n, 1);
    chk("rst_mosi", bus_if.mosi, 0);
    chk("rst_rd_data", bus_if.rd_data, 8'h00);
    chk("rst_rd_valid", bus_if.rd_valid, 0);

    // 1: basic 4-byte read
    flash_data = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    hs0 = hs_cnt; d0 = done_cnt;
    start_read(24'h000100, 16'd4);
    wait_done("t1", 2000);
    chk("t1_header", mosi_cap, hdr_exp(24'h000100));
    chk("t1_rises", rise_cnt, HDR + 32);
    chk("t1_first_rise", first_rise_cyc - cs_fall_cyc, 2);
    chk("t1_bit_span", last_rise_cyc - first_rise_cyc, (rise_cnt - 1) * 4);
    chk("t1_cs_release", cs_rise_cyc - last_fall_cyc, 2);
    chk("t1_data_mosi", data_mosi_err, 0);
    chk("t1_handshakes", hs_cnt - hs0, 4);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_queue_empty", exp_q.size(), 0);

    // 2: 50-cycle backpressure after first rd_valid
    hs0 = hs_cnt;
    @(posedge sys_clk); #1 bus_if.rd_ready = 1'b0;
    start_read(24'h000100, 16'd4);
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (bus_if.rd_valid) begin got = 1; break; end
    end
    chk("t2_valid_seen", got, 1);
    repeat (40) @(negedge sys_clk);
    r40 = rise_cnt;
    repeat (10) @(negedge sys_clk);
    chk("t2_frozen", rise_cnt, r40);
    chk("t2_stall_rises", rise_cnt, HDR + 16);
    chk("t2_stall_sck", bus_if.sck, 0);
    chk("t2_stall_cs_n", bus_if.cs_n, 0);
    @(posedge sys_clk); #1 bus_if.rd_ready = 1'b1;
    wait_done("t2", 2000);
    chk("t2_handshakes", hs_cnt - hs0, 4);
    chk("t2_queue_empty", exp_q.size(), 0);

    // 3: zero-length read
    busy_seen = 0; r40 = rise_cnt;
    @(posedge sys_clk); #1 start = 1'b1; start_addr = 24'h000100; byte_cnt = 16'd0;
    @(posedge sys_clk); #1 start = 1'b0;
    @(negedge sys_clk);
    chk("t3_done", done, 1);
    chk("t3_cs_n", bus_if.cs_n, 1);
    @(negedge sys_clk);
    chk("t3_done_once", done, 0);
    chk("t3_busy_never", busy_seen, 0);
    chk("t3_no_sck", rise_cnt, r40);

    // 4: start during ADDR is ignored
    flash_data[0] = 8'h11; flash_data[1] = 8'h22;
    hs0 = hs_cnt;
    start_read(24'h000100, 16'd2);
    wait_rise(12, 500);
    @(posedge sys_clk); #1 start = 1'b1; start_addr = 24'hFFFFFF; byte_cnt = 16'd7;
    @(posedge sys_clk); #1 start = 1'b0;
    wait_done("t4", 2000);
    chk("t4_header", mosi_cap, hdr_exp(24'h000100));
    chk("t4_handshakes", hs_cnt - hs0, 2);

    // 5: abort in byte 2, reset in CMD, then a clean 2-byte read
    flash_data = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    d0 = done_cnt;
    start_read(24'h000400, 16'd4);
    wait_rise(HDR + 10, 1000);
    @(posedge sys_clk); #1 abort = 1'b1;
    @(posedge sys_clk); #1 abort = 1'b0;
    @(negedge sys_clk);
    chk("t5_abort_cs_n", bus_if.cs_n, 1);
    chk("t5_abort_sck", bus_if.sck, 0);
    chk("t5_abort_valid", bus_if.rd_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_left", exp_q.size(), 3);
    exp_q.delete();
    start_read(24'h000400, 16'd4);
    wait_rise(4, 200);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_rst_cs_n", bus_if.cs_n, 1);
    chk("t5_rst_sck", bus_if.sck, 0);
    chk("t5_rst_valid", bus_if.rd_valid, 0);
    chk("t5_rst_busy", busy, 0);
    exp_q.delete();
    repeat (5) @(negedge sys_clk);
    chk("t5_no_done", done_cnt - d0, 0);
    flash_data[0] = 8'h5C; flash_data[1] = 8'hE7;
    hs0 = hs_cnt;
    start_read(24'h000010, 16'd2);
    wait_done("t5", 2000);
    chk("t5_handshakes", hs_cnt - hs0, 2);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: single byte; header and capture point depend on the read opcode
    flash_data[0] = 8'h81;
    start_read(24'h000200, 16'd1);
    wait_done("t6", 2000);
    chk("t6_header", mosi_cap, hdr_exp(24'h000200));
    chk("t6_capture_rise", valid_rise_at, HDR + 8);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
